test_pipe_datapath: RTL



---
 rtl/test_pipe_datapath.sv | 124 ++++++++++++
 1 files changed

// File: rtl/test_pipe_datapath.sv
// WIDTH-bit gate/adder datapath feeding a DEPTH-stage valid-tagged pipeline,
// followed by an XOR accumulator and a saturating emitted-sample counter.
module test_pipe_datapath #(
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 2,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   c,
  input  logic               clr,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out1,
  output logic [WIDTH-1:0]   out2,
  output logic [WIDTH-1:0]   acc,
  output logic [COUNT_W-1:0] count
);

  logic [WIDTH-1:0]   and_ab_s, or_bc_s, xor_r_s, sum_s, sel_s;
  logic [DEPTH-1:0]   v_q, v_d, v_in_s;
  logic [WIDTH-1:0]   na_q [DEPTH];
  logic [WIDTH-1:0]   na_d [DEPTH];
  logic [WIDTH-1:0]   na_in_s [DEPTH];
  logic [WIDTH-1:0]   r_q [DEPTH];
  logic [WIDTH-1:0]   r_d [DEPTH];
  logic [WIDTH-1:0]   r_in_s [DEPTH];
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [COUNT_W-1:0] count_q, count_d;

  assign and_ab_s = a & b;
  assign or_bc_s  = b | c;
  assign xor_r_s  = and_ab_s ^ or_bc_s;
  assign sum_s    = a + b;

  // Operation select
  always_comb begin
    sel_s = xor_r_s;
    case (mode)
      2'd0:    sel_s = xor_r_s;
      2'd1:    sel_s = and_ab_s;
      2'd2:    sel_s = or_bc_s;
      2'd3:    sel_s = sum_s;
      default: sel_s = xor_r_s;
    endcase
  end

  assign v_in_s[0]  = in_valid;
  assign na_in_s[0] = ~a;
  assign r_in_s[0]  = sel_s;

  for (genvar g = 1; g < DEPTH; g++) begin : g_link
    assign v_in_s[g]  = v_q[g-1];
    assign na_in_s[g] = na_q[g-1];
    assign r_in_s[g]  = r_q[g-1];
  end

  // Stage next-state: valid always shifts, data loads only behind a valid bit
  always_comb begin
    v_d = v_in_s;
    for (int i = 0; i < DEPTH; i++) begin
      na_d[i] = na_q[i];
      r_d[i]  = r_q[i];
      if (v_in_s[i]) begin
        na_d[i] = na_in_s[i];
        r_d[i]  = r_in_s[i];
      end else begin
        na_d[i] = na_q[i];
        r_d[i]  = r_q[i];
      end
    end
  end

  // Accumulator/counter next-state; clr takes priority over an emitted sample
  always_comb begin
    acc_d   = acc_q;
    count_d = count_q;
    if (clr) begin
      acc_d   = '0;
      count_d = '0;
    end else if (out_valid) begin
      acc_d = acc_q ^ out2;
      if (count_q != {COUNT_W{1'b1}}) begin
        count_d = count_q + COUNT_W'(1'b1);
      end else begin
        count_d = count_q;
      end
    end else begin
      acc_d   = acc_q;
      count_d = count_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q     <= '0;
      acc_q   <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        na_q[i] <= '0;
        r_q[i]  <= '0;
      end
    end else begin
      v_q     <= v_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        na_q[i] <= na_d[i];
        r_q[i]  <= r_d[i];
      end
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out2      = r_q[DEPTH-1];
  assign out1      = na_q[DEPTH-1] & r_q[DEPTH-1];
  assign acc       = acc_q;
  assign count     = count_q;

endmodule
